// File: rtl/sdram_loader_if.sv
// sdram_loader_if: byte-wide SDRAM controller bus.
// master (loader) drives addr/din/we/rd; slave (controller) drives dout/ready.
//   addr  25  byte address
//   din    8  write data
//   we     1  write strobe
//   rd     1  read strobe
//   dout   8  read data
//   ready  1  controller idle / access complete
interface sdram_loader_if;
    logic [24:0] addr;
    logic [7:0]  din;
    logic        we;
    logic        rd;
    logic [7:0]  dout;
    logic        ready;
    modport master (output addr, din, we, rd, input dout, ready);
    modport slave  (input addr, din, we, rd, output dout, ready);
endinterface

// File: rtl/sdram_loader.sv
// sdram_loader: buffers the HPS ioctl download in a small FIFO and replays each byte,
// plus single-byte CPU reads, into the SDRAM controller's strobe/ready handshake.
//   clk, reset_n        system clock, synchronous active-low reset
//   ioctl_download/wr   download window and one-cycle byte-valid pulse
//   ioctl_addr/dout     download byte address and data
//   ioctl_wait          registered backpressure to the HPS
//   cpu_rd/cpu_addr     level read request (rising edge starts a read) and its address
//   cpu_dout/cpu_ready  read data and its one-cycle valid pulse
//   mem                 controller bus (master side)
//   load_done           one-cycle pulse once a finished download is fully committed
//   overflow            sticky: a byte was dropped on a full FIFO
module sdram_loader #(
    parameter int FIFO_DEPTH = 4,
    parameter int GUARD      = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ioctl_download,
    input  logic                  ioctl_wr,
    input  logic [24:0]           ioctl_addr,
    input  logic [7:0]            ioctl_dout,
    output logic                  ioctl_wait,
    input  logic                  cpu_rd,
    input  logic [24:0]           cpu_addr,
    output logic [7:0]            cpu_dout,
    output logic                  cpu_ready,
    sdram_loader_if.master        mem,
    output logic                  load_done,
    output logic                  overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (GUARD > 1) ? $clog2(GUARD + 1) : 1;

    typedef enum logic [2:0] {IDLE, STROBE, GUARD_W, WAIT_RDY, DONE} state_t;

    logic [32:0]   fifo_mem [FIFO_DEPTH];
    logic [32:0]   head;
    logic          empty, full, push, push_ok, pop;
    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [GW-1:0] guard_q, guard_d;
    logic          op_rd_q, op_rd_d;
    logic [24:0]   mem_addr_q, mem_addr_d, rd_addr_q, rd_addr_d;
    logic [7:0]    mem_din_q, mem_din_d, cpu_dout_q, cpu_dout_d;
    logic          mem_we_q, mem_we_d, mem_rd_q, mem_rd_d;
    logic          cpu_ready_q, cpu_ready_d, pend_q, pend_d;
    logic          cpu_rd_prev_q, cpu_rd_prev_d, dl_prev_q, dl_prev_d;
    logic          fall_pend_q, fall_pend_d, load_done_q, load_done_d;
    logic          ioctl_wait_q, ioctl_wait_d, overflow_q, overflow_d;

    always_comb begin
        empty         = count_q == '0;
        full          = count_q == CW'(FIFO_DEPTH);
        push          = ioctl_wr & ioctl_download;
        push_ok       = push & ~full;
        pop           = (state_q == IDLE) & ~empty;
        head          = fifo_mem[rd_ptr_q];
        wr_ptr_d      = wr_ptr_q + AW'(push_ok);
        rd_ptr_d      = rd_ptr_q + AW'(pop);
        count_d       = count_q + CW'(push_ok) - CW'(pop);
        overflow_d    = overflow_q | (push & full);
        // Asserting one entry early leaves a slot for a pulse already in flight.
        ioctl_wait_d  = count_q >= CW'(FIFO_DEPTH - 1);
        cpu_rd_prev_d = cpu_rd;
        dl_prev_d     = ioctl_download;
        state_d       = state_q;
        guard_d       = guard_q;
        op_rd_d       = op_rd_q;
        mem_addr_d    = mem_addr_q;
        mem_din_d     = mem_din_q;
        mem_we_d      = 1'b0;
        mem_rd_d      = 1'b0;
        cpu_dout_d    = cpu_dout_q;
        cpu_ready_d   = 1'b0;
        pend_d        = pend_q;
        rd_addr_d     = rd_addr_q;
        case (state_q)
            IDLE: begin
                // Writes win over reads; reads also wait out the download window.
                if (!empty) begin
                    mem_addr_d = head[32:8];
                    mem_din_d  = head[7:0];
                    mem_we_d   = 1'b1;
                    op_rd_d    = 1'b0;
                    state_d    = STROBE;
                end else if (pend_q && !ioctl_download) begin
                    mem_addr_d = rd_addr_q;
                    mem_rd_d   = 1'b1;
                    op_rd_d    = 1'b1;
                    state_d    = STROBE;
                end
            end
            STROBE: begin
                guard_d = GW'(GUARD);
                state_d = GUARD_W;
            end
            GUARD_W: begin
                // ready is still high from before the strobe; ignore it here.
                guard_d = guard_q - GW'(1);
                if (guard_q <= GW'(1)) state_d = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (mem.ready) begin
                    state_d = IDLE;
                    if (op_rd_q) begin
                        cpu_dout_d  = mem.dout;
                        cpu_ready_d = 1'b1;
                        pend_d      = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A new edge after the completion check so a coincident request is not lost.
        if (cpu_rd && !cpu_rd_prev_q) begin
            pend_d    = 1'b1;
            rd_addr_d = cpu_addr;
        end
        fall_pend_d = fall_pend_q | (dl_prev_q & ~ioctl_download);
        load_done_d = (state_q == IDLE) & empty & ~ioctl_download & fall_pend_d;
        if (load_done_d) fall_pend_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr_q] <= {ioctl_addr, ioctl_dout};
        if (!reset_n) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            guard_q       <= '0;
            op_rd_q       <= 1'b0;
            mem_addr_q    <= '0;
            mem_din_q     <= '0;
            mem_we_q      <= 1'b0;
            mem_rd_q      <= 1'b0;
            cpu_dout_q    <= '0;
            cpu_ready_q   <= 1'b0;
            pend_q        <= 1'b0;
            rd_addr_q     <= '0;
            cpu_rd_prev_q <= 1'b0;
            dl_prev_q     <= 1'b0;
            fall_pend_q   <= 1'b0;
            load_done_q   <= 1'b0;
            ioctl_wait_q  <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            guard_q       <= guard_d;
            op_rd_q       <= op_rd_d;
            mem_addr_q    <= mem_addr_d;
            mem_din_q     <= mem_din_d;
            mem_we_q      <= mem_we_d;
            mem_rd_q      <= mem_rd_d;
            cpu_dout_q    <= cpu_dout_d;
            cpu_ready_q   <= cpu_ready_d;
            pend_q        <= pend_d;
            rd_addr_q     <= rd_addr_d;
            cpu_rd_prev_q <= cpu_rd_prev_d;
            dl_prev_q     <= dl_prev_d;
            fall_pend_q   <= fall_pend_d;
            load_done_q   <= load_done_d;
            ioctl_wait_q  <= ioctl_wait_d;
            overflow_q    <= overflow_d;
        end
    end

    assign mem.addr   = mem_addr_q;
    assign mem.din    = mem_din_q;
    assign mem.we     = mem_we_q;
    assign mem.rd     = mem_rd_q;
    assign cpu_dout   = cpu_dout_q;
    assign cpu_ready  = cpu_ready_q;
    assign ioctl_wait = ioctl_wait_q;
    assign load_done  = load_done_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_sdram_loader.sv
// tb_sdram_loader: self-checking bench for sdram_loader with a behavioural SDRAM controller model.
module tb_sdram_loader;
    logic        clk = 1'b0;
    logic        reset_n, ioctl_download, ioctl_wr, cpu_rd;
    logic [24:0] ioctl_addr, cpu_addr;
    logic [7:0]  ioctl_dout, cpu_dout;
    logic        ioctl_wait, cpu_ready, load_done, overflow;

    sdram_loader_if mem();

    sdram_loader #(.FIFO_DEPTH(4), .GUARD(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
        .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_ready(cpu_ready),
        .mem(mem), .load_done(load_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int wr_strobes = 0;
    int rd_strobes = 0;
    int rd_cyc = 0;
    int rdy_cyc = 0;
    logic we_last = 1'b0;
    logic rd_last = 1'b0;
    logic [32:0] exp_wr[$];
    logic [32:0] exp_rd[$];

    // Controller model: ready drops on a strobe and returns 6 cycles later;
    // stall freezes it low, owm answers reads from the open word with ready held high.
    logic       m_ready = 1'b1;
    logic [7:0] m_dout = 8'h00;
    int         m_busy = 0;
    logic       stall = 1'b0;
    logic       owm = 1'b0;
    logic [7:0] smem [1024];

    assign mem.ready = m_ready;
    assign mem.dout  = m_dout;

    always @(posedge clk) begin
        if (mem.we) begin
            smem[mem.addr[9:0]] <= mem.din;
            m_ready <= 1'b0;
            m_busy  <= 6;
        end else if (mem.rd) begin
            m_dout <= smem[mem.addr[9:0]];
            if (!owm) begin
                m_ready <= 1'b0;
                m_busy  <= 6;
            end
        end else if (!m_ready && !stall) begin
            m_busy <= m_busy - 1;
            if (m_busy <= 1) m_ready <= 1'b1;
        end
    end

    // Scoreboard: pop expected writes on each we edge, expected reads on rd edge / cpu_ready.
    always @(negedge clk) begin
        logic [32:0] e;
        cyc++;
        if (reset_n) begin
            if (mem.we && !we_last) begin
                wr_strobes++;
                checks++;
                if (exp_wr.size() == 0) begin
                    $display("FAIL wr_unexpected got %h:%h want none", mem.addr, mem.din);
                end else begin
                    e = exp_wr.pop_front();
                    if ({mem.addr, mem.din} !== e)
                        $display("FAIL wr_order got %h:%h want %h:%h", mem.addr, mem.din, e[32:8], e[7:0]);
                    else passes++;
                end
            end
            if (mem.rd && !rd_last) begin
                rd_strobes++;
                rd_cyc = cyc;
                checks++;
                if (exp_rd.size() == 0) $display("FAIL rd_unexpected got %h want none", mem.addr);
                else if (mem.addr !== exp_rd[0][32:8])
                    $display("FAIL rd_addr got %h want %h", mem.addr, exp_rd[0][32:8]);
                else passes++;
            end
            if (cpu_ready) begin
                rdy_cyc = cyc;
                checks++;
                if (exp_rd.size() == 0) begin
                    $display("FAIL cpu_ready_unexpected got %h want none", cpu_dout);
                end else begin
                    e = exp_rd.pop_front();
                    if (cpu_dout !== e[7:0]) $display("FAIL cpu_dout got %h want %h", cpu_dout, e[7:0]);
                    else passes++;
                end
            end
        end
        we_last = mem.we;
        rd_last = mem.rd;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1);
    end

    task automatic count_done(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            @(negedge clk);
            if (load_done) pulses++;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (mem.we !== 1'b0) $display("FAIL rst_we got %b want 0", mem.we); else passes++;
        checks++; if (mem.rd !== 1'b0) $display("FAIL rst_rd got %b want 0", mem.rd); else passes++;
        checks++; if (mem.addr !== 25'h0) $display("FAIL rst_addr got %h want 0", mem.addr); else passes++;
        checks++; if (mem.din !== 8'h0) $display("FAIL rst_din got %h want 0", mem.din); else passes++;
        checks++; if (cpu_dout !== 8'h0) $display("FAIL rst_cpu_dout got %h want 0", cpu_dout); else passes++;
        checks++; if (cpu_ready !== 1'b0) $display("FAIL rst_cpu_ready got %b want 0", cpu_ready); else passes++;
        checks++; if (ioctl_wait !== 1'b0) $display("FAIL rst_wait got %b want 0", ioctl_wait); else passes++;
        checks++; if (load_done !== 1'b0) $display("FAIL rst_done got %b want 0", load_done); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL rst_overflow got %b want 0", overflow); else passes++;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_write;
        int p;
        ioctl_download = 1'b1;
        @(negedge clk);
        ioctl_wr = 1'b1; ioctl_addr = 25'h000123; ioctl_dout = 8'hA5;
        exp_wr.push_back({25'h000123, 8'hA5});
        @(negedge clk);
        ioctl_wr = 1'b0;
        checks++; if (mem.we !== 1'b0) $display("FAIL sw_we_t1 got %b want 0", mem.we); else passes++;
        @(negedge clk);
        checks++;
        if (mem.we !== 1'b1 || mem.addr !== 25'h000123 || mem.din !== 8'hA5)
            $display("FAIL sw_strobe got %b %h %h want 1 000123 a5", mem.we, mem.addr, mem.din);
        else passes++;
        @(negedge clk);
        checks++; if (mem.we !== 1'b0) $display("FAIL sw_we_width got %b want 0", mem.we); else passes++;
        checks++; if (mem.addr !== 25'h000123) $display("FAIL sw_addr_hold got %h want 000123", mem.addr); else passes++;
        count_done(15, p);
        checks++; if (p != 0) $display("FAIL sw_done_early got %0d want 0", p); else passes++;
        ioctl_download = 1'b0;
        count_done(20, p);
        checks++; if (p != 1) $display("FAIL sw_done_pulses got %0d want 1", p); else passes++;
        checks++; if (exp_wr.size() != 0) $display("FAIL sw_drain got %0d want 0", exp_wr.size()); else passes++;
    endtask

    task automatic test_burst;
        int i, cnt, cnt_prev, p;
        logic pushed, we_l, seen_wait;
        i = 0; cnt = 0; pushed = 1'b0; seen_wait = 1'b0; we_l = mem.we;
        ioctl_download = 1'b1;
        for (int n = 0; n < 400 && (i < 8 || exp_wr.size() != 0); n++) begin
            if (i < 8 && !ioctl_wait) begin
                ioctl_wr = 1'b1; ioctl_addr = 25'h10 + 25'(i); ioctl_dout = 8'h3C + 8'(i);
                exp_wr.push_back({ioctl_addr, ioctl_dout});
                pushed = 1'b1;
                i++;
            end else begin
                ioctl_wr = 1'b0;
                pushed = 1'b0;
            end
            @(negedge clk);
            cnt_prev = cnt;
            cnt = cnt + int'(pushed) - ((mem.we && !we_l) ? 1 : 0);
            we_l = mem.we;
            if (ioctl_wait) seen_wait = 1'b1;
            checks++;
            if (ioctl_wait !== (cnt_prev >= 3))
                $display("FAIL bu_wait got %b want %b (count %0d)", ioctl_wait, cnt_prev >= 3, cnt_prev);
            else passes++;
        end
        ioctl_wr = 1'b0;
        checks++; if (!seen_wait) $display("FAIL bu_wait_seen got 0 want 1"); else passes++;
        checks++; if (exp_wr.size() != 0 || i != 8) $display("FAIL bu_drain got %0d left want 0", exp_wr.size()); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL bu_overflow got %b want 0", overflow); else passes++;
        ioctl_download = 1'b0;
        count_done(20, p);
        checks++; if (p != 1) $display("FAIL bu_done_pulses got %0d want 1", p); else passes++;
    endtask

    task automatic test_cpu_read;
        int p;
        exp_rd.push_back({25'h10, 8'h3C});
        cpu_addr = 25'h10; cpu_rd = 1'b1;
        p = 0;
        repeat (30) begin
            @(negedge clk);
            if (cpu_ready) p++;
        end
        checks++; if (p != 1) $display("FAIL rd_ready_pulses got %0d want 1", p); else passes++;
        checks++; if (cpu_dout !== 8'h3C) $display("FAIL rd_dout_stable got %h want 3c", cpu_dout); else passes++;
        checks++; if (exp_rd.size() != 0) $display("FAIL rd_complete got %0d left want 0", exp_rd.size()); else passes++;
        cpu_rd = 1'b0; owm = 1'b1;
        @(negedge clk);
        rd_cyc = 0; rdy_cyc = 0;
        exp_rd.push_back({25'h11, 8'h3D});
        cpu_addr = 25'h11; cpu_rd = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (rdy_cyc - rd_cyc != 4) $display("FAIL owm_latency got %0d want 4", rdy_cyc - rd_cyc); else passes++;
        checks++; if (cpu_dout !== 8'h3D) $display("FAIL owm_dout got %h want 3d", cpu_dout); else passes++;
        checks++; if (exp_rd.size() != 0) $display("FAIL owm_complete got %0d left want 0", exp_rd.size()); else passes++;
        cpu_rd = 1'b0; owm = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_during_download;
        int rd0, wr0, p, d;
        rd0 = rd_strobes; wr0 = wr_strobes;
        ioctl_download = 1'b1;
        @(negedge clk);
        ioctl_wr = 1'b1; ioctl_addr = 25'h200; ioctl_dout = 8'h11;
        exp_wr.push_back({25'h200, 8'h11});
        exp_rd.push_back({25'h200, 8'h11});
        cpu_addr = 25'h200; cpu_rd = 1'b1;
        @(negedge clk);
        ioctl_addr = 25'h201; ioctl_dout = 8'h22;
        exp_wr.push_back({25'h201, 8'h22});
        @(negedge clk);
        ioctl_wr = 1'b0;
        repeat (40) @(negedge clk);
        checks++; if (rd_strobes != rd0) $display("FAIL rdd_held got %0d reads want 0", rd_strobes - rd0); else passes++;
        checks++; if (wr_strobes - wr0 != 2) $display("FAIL rdd_writes got %0d want 2", wr_strobes - wr0); else passes++;
        ioctl_download = 1'b0;
        p = 0; d = 0;
        repeat (30) begin
            @(negedge clk);
            if (cpu_ready) p++;
            if (load_done) d++;
        end
        checks++; if (p != 1) $display("FAIL rdd_ready got %0d want 1", p); else passes++;
        checks++; if (d != 1) $display("FAIL rdd_done got %0d want 1", d); else passes++;
        checks++; if (cpu_dout !== 8'h11) $display("FAIL rdd_dout got %h want 11", cpu_dout); else passes++;
        cpu_rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_overflow;
        int p, n;
        stall = 1'b1;
        ioctl_download = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ioctl_wr = 1'b1; ioctl_addr = 25'h100 + 25'(i); ioctl_dout = 8'h80 + 8'(i);
            if (i < 5) exp_wr.push_back({ioctl_addr, ioctl_dout});
            @(negedge clk);
        end
        ioctl_wr = 1'b0;
        checks++; if (overflow !== 1'b1) $display("FAIL ov_set got %b want 1", overflow); else passes++;
        repeat (5) @(negedge clk);
        stall = 1'b0;
        n = 0;
        while (exp_wr.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (12) @(negedge clk);
        checks++; if (exp_wr.size() != 0) $display("FAIL ov_drain got %0d left want 0", exp_wr.size()); else passes++;
        checks++; if (overflow !== 1'b1) $display("FAIL ov_sticky got %b want 1", overflow); else passes++;
        ioctl_download = 1'b0;
        count_done(20, p);
        checks++; if (p != 1) $display("FAIL ov_done got %0d want 1", p); else passes++;
        checks++; if (overflow !== 1'b1) $display("FAIL ov_sticky2 got %b want 1", overflow); else passes++;
    endtask

    task automatic test_reset_mid;
        int w1, p;
        logic [44:0] outs;
        ioctl_download = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ioctl_wr = 1'b1; ioctl_addr = 25'h300 + 25'(i); ioctl_dout = 8'h90 + 8'(i);
            if (i == 0) exp_wr.push_back({ioctl_addr, ioctl_dout});
            @(negedge clk);
        end
        ioctl_wr = 1'b0;
        w1 = wr_strobes;
        checks++; if (exp_wr.size() != 0) $display("FAIL rm_inflight got %0d left want 0", exp_wr.size()); else passes++;
        reset_n = 1'b0;
        @(negedge clk);
        outs = {mem.we, mem.rd, mem.addr, mem.din, cpu_ready, ioctl_wait, load_done, overflow};
        checks++; if (outs !== 45'h0) $display("FAIL rm_reset_vals got %h want 0", outs); else passes++;
        checks++; if (cpu_dout !== 8'h0) $display("FAIL rm_cpu_dout got %h want 0", cpu_dout); else passes++;
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        checks++; if (wr_strobes != w1) $display("FAIL rm_flushed got %0d strobes want 0", wr_strobes - w1); else passes++;
        ioctl_wr = 1'b1; ioctl_addr = 25'h310; ioctl_dout = 8'h5A;
        exp_wr.push_back({25'h310, 8'h5A});
        @(negedge clk);
        ioctl_wr = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (exp_wr.size() != 0) $display("FAIL rm_new_write got %0d left want 0", exp_wr.size()); else passes++;
        ioctl_download = 1'b0;
        count_done(20, p);
        checks++; if (p != 1) $display("FAIL rm_done got %0d want 1", p); else passes++;
    endtask

    initial begin
        reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
        cpu_rd = 1'b0; cpu_addr = '0;
        test_reset();
        test_single_write();
        test_burst();
        test_cpu_read();
        test_read_during_download();
        test_overflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
